// File: rtl/hopfield_seq.sv
// Recall sequencer for a fully connected Hopfield network: walks the weight
// memory row by row, accumulates signed weighted sums and updates one neuron at a time.
module hopfield_seq #(
  parameter int N = 25,
  parameter int WW = 8,
  parameter int SW = 13,
  parameter int AW = 10,
  parameter int MAX_SWEEPS = 8,
  parameter logic [N-1:0] INIT_PATTERN = {N{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load,
  input  logic [N-1:0]         pattern_in,
  output logic [AW-1:0]        w_addr,
  output logic                 w_rd,
  input  logic signed [WW-1:0] w_data,
  output logic [N-1:0]         neurons,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [3:0]           sweep_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
  localparam logic [3:0] SWEEP_LIMIT = 4'(MAX_SWEEPS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    UPDATE = 3'd3,
    CHECK  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [IW-1:0]       i_r;
  logic [IW-1:0]       j_r;
  logic [IW-1:0]       jp_r;
  logic signed [SW-1:0] acc_r;
  logic signed [SW-1:0] term_s;
  logic [N-1:0]        neurons_r;
  logic                flip_r;
  logic                new_bit_s;
  logic                acc_en_s;
  logic [AW-1:0]       addr_r;
  logic                w_rd_r;
  logic                busy_r;
  logic                done_r;
  logic                converged_r;
  logic [3:0]          sweep_r;

  // Signed contribution of one weight: +w for a +1 neuron, -w for a -1 neuron, 0 on the diagonal.
  function automatic logic signed [SW-1:0] term_f(input logic [WW-1:0] w,
                                                  input logic pos,
                                                  input logic diag);
    logic signed [SW-1:0] ext;
    ext = $signed({{(SW-WW){w[WW-1]}}, w});
    if (diag) begin
      term_f = {SW{1'b0}};
    end else if (pos) begin
      term_f = ext;
    end else begin
      term_f = -ext;
    end
  endfunction

  assign w_addr    = addr_r;
  assign w_rd      = w_rd_r;
  assign neurons   = neurons_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign converged = converged_r;
  assign sweep_cnt = sweep_r;

  // Next-state decode plus the term/threshold datapath.
  always_comb begin
    state_s  = state_r;
    term_s   = term_f(w_data, neurons_r[jp_r], (jp_r == i_r));
    acc_en_s = 1'b0;
    if (acc_r[SW-1]) begin
      new_bit_s = 1'b0;
    end else if (acc_r != {SW{1'b0}}) begin
      new_bit_s = 1'b1;
    end else begin
      new_bit_s = neurons_r[i_r];
    end
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = IDLE;
        end else if (start) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        acc_en_s = (j_r != ZERO_IDX);
        if (j_r == LAST_IDX) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        acc_en_s = 1'b1;
        state_s  = UPDATE;
      end
      UPDATE: begin
        if (i_r == LAST_IDX) begin
          state_s = CHECK;
        end else begin
          state_s = FETCH;
        end
      end
      CHECK: begin
        if (!flip_r) begin
          state_s = FIN;
        end else if ((sweep_r + 4'd1) == SWEEP_LIMIT) begin
          state_s = FIN;
        end else begin
          state_s = FETCH;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state, counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      i_r         <= ZERO_IDX;
      j_r         <= ZERO_IDX;
      jp_r        <= ZERO_IDX;
      acc_r       <= {SW{1'b0}};
      neurons_r   <= INIT_PATTERN;
      flip_r      <= 1'b0;
      addr_r      <= {AW{1'b0}};
      w_rd_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      converged_r <= 1'b0;
      sweep_r     <= 4'd0;
    end else begin
      state_r <= state_s;
      w_rd_r  <= (state_s == FETCH);
      done_r  <= (state_s == FIN);
      jp_r    <= j_r;
      if (acc_en_s) begin
        acc_r <= acc_r + term_s;
      end
      case (state_r)
        IDLE: begin
          if (load) begin
            neurons_r <= pattern_in;
          end else if (start) begin
            i_r         <= ZERO_IDX;
            j_r         <= ZERO_IDX;
            sweep_r     <= 4'd0;
            flip_r      <= 1'b0;
            converged_r <= 1'b0;
            addr_r      <= {AW{1'b0}};
            busy_r      <= 1'b1;
          end
        end
        FETCH: begin
          // Address runs straight on across rows: i*N+24 + 1 == (i+1)*N.
          addr_r <= addr_r + AW'(1);
          j_r    <= j_r + IW'(1);
          if (j_r == ZERO_IDX) begin
            acc_r <= {SW{1'b0}};
          end
        end
        DRAIN: begin
          j_r <= ZERO_IDX;
        end
        UPDATE: begin
          neurons_r[i_r] <= new_bit_s;
          if (new_bit_s != neurons_r[i_r]) begin
            flip_r <= 1'b1;
          end
          if (i_r != LAST_IDX) begin
            i_r <= i_r + IW'(1);
          end
        end
        CHECK: begin
          sweep_r <= sweep_r + 4'd1;
          if (!flip_r) begin
            converged_r <= 1'b1;
          end else if ((sweep_r + 4'd1) == SWEEP_LIMIT) begin
            converged_r <= 1'b0;
          end else begin
            flip_r <= 1'b0;
            i_r    <= ZERO_IDX;
            addr_r <= {AW{1'b0}};
          end
        end
        FIN: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hopfield_seq.sv
// Directed bench for hopfield_seq: weight memory model, result scoreboard and
// an address monitor for the read-port sequence.
module tb_hopfield_seq;

  logic              clk;
  logic              rst;
  logic              start;
  logic              load;
  logic [24:0]       pattern_in;
  logic [9:0]        w_addr;
  logic              w_rd;
  logic signed [7:0] w_data;
  logic [24:0]       neurons;
  logic              busy;
  logic              done;
  logic              converged;
  logic [3:0]        sweep_cnt;

  typedef struct {
    logic [24:0] nrn;
    logic        conv;
    logic [3:0]  sw;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          addr_q[$];
  logic signed [7:0] wmem [625];
  int          checks;
  int          failures;
  bit          addr_chk;
  int          run_len;

  hopfield_seq dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .pattern_in(pattern_in),
    .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data), .neurons(neurons),
    .busy(busy), .done(done), .converged(converged), .sweep_cnt(sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read weight memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (w_rd) w_data <= wmem[int'(w_addr)];
    else      w_data <= 8'sd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address monitor: every strobe must match the next queued address, runs are 25 long.
  always @(negedge clk) begin
    if (addr_chk) begin
      if (w_rd) begin
        if (addr_q.size() == 0) begin
          chk("addr_extra", {22'd0, w_addr}, 32'hFFFF_FFFF);
        end else begin
          chk("w_addr", {22'd0, w_addr}, addr_q.pop_front());
        end
        run_len++;
      end else if (run_len != 0) begin
        chk("rd_run_len", run_len, 32'd25);
        run_len = 0;
      end
    end
  end

  task automatic clear_w();
    for (int k = 0; k < 625; k++) wmem[k] = 8'sd0;
  endtask

  task automatic load_pat(input logic [24:0] p);
    @(negedge clk);
    load = 1'b1;
    pattern_in = p;
    @(negedge clk);
    load = 1'b0;
    chk("load_neurons", {7'd0, neurons}, {7'd0, p});
  endtask

  task automatic push_exp(input logic [24:0] nrn, input logic conv, input logic [3:0] sw);
    exp_t e;
    e.nrn  = nrn;
    e.conv = conv;
    e.sw   = sw;
    e.lat  = 2 + 676 * int'(sw);
    sb.push_back(e);
  endtask

  // Pulse start and wait for done; cycle 1 is the cycle in which start is high.
  task automatic run_pop(input string tag);
    exp_t e;
    int c;
    @(negedge clk);
    start = 1'b1;
    c = 1;
    @(negedge clk);
    start = 1'b0;
    c = 2;
    while (!done && c < 12000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, c, e.lat);
    chk({tag, "_neurons"}, {7'd0, neurons}, {7'd0, e.nrn});
    chk({tag, "_converged"}, {31'd0, converged}, {31'd0, e.conv});
    chk({tag, "_sweep_cnt"}, {28'd0, sweep_cnt}, {28'd0, e.sw});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    bit seen;
    checks = 0;
    failures = 0;
    addr_chk = 1'b0;
    run_len = 0;
    rst = 1'b0;
    start = 1'b0;
    load = 1'b0;
    pattern_in = 25'd0;
    clear_w();
    repeat (3) @(negedge clk);
    chk("rst_neurons", {7'd0, neurons}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_converged", {31'd0, converged}, 32'd0);
    chk("rst_sweep_cnt", {28'd0, sweep_cnt}, 32'd0);
    chk("rst_w_rd", {31'd0, w_rd}, 32'd0);
    chk("rst_w_addr", {22'd0, w_addr}, 32'd0);
    rst = 1'b1;

    // All-zero weights: one quiet sweep.
    load_pat(25'h1555555);
    push_exp(25'h1555555, 1'b1, 4'd1);
    run_pop("zero_w");

    // Single positive weight pulls neuron 0 up to match neuron 1.
    clear_w();
    wmem[1] = 8'sd5;
    load_pat(25'h0000002);
    push_exp(25'h0000003, 1'b1, 4'd2);
    run_pop("one_w");

    // Two-neuron oscillator runs into the sweep limit.
    clear_w();
    wmem[1]  = -8'sd1;
    wmem[25] = 8'sd1;
    load_pat(25'h0000003);
    push_exp(25'h0000003, 1'b0, 4'd8);
    run_pop("osc");

    // Positive diagonal only, plus the full read-address sequence.
    clear_w();
    for (int k = 0; k < 25; k++) wmem[k * 26] = 8'sd100;
    for (int k = 0; k < 625; k++) addr_q.push_back(k);
    load_pat(25'h0000000);
    addr_chk = 1'b1;
    push_exp(25'h0000000, 1'b1, 4'd1);
    run_pop("diag_pos");
    addr_chk = 1'b0;
    chk("addr_left", addr_q.size(), 32'd0);

    // Negative diagonal would flip every neuron if it were not ignored.
    clear_w();
    for (int k = 0; k < 25; k++) wmem[k * 26] = -8'sd100;
    load_pat(25'h0AAAAAA);
    push_exp(25'h0AAAAAA, 1'b1, 4'd1);
    run_pop("diag_neg");

    // load and start together: load wins, no run starts.
    @(negedge clk);
    load = 1'b1;
    start = 1'b1;
    pattern_in = 25'h000001F;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    chk("ldst_neurons", {7'd0, neurons}, 32'h1F);
    chk("ldst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ldst_busy2", {31'd0, busy}, 32'd0);

    // Reset in the middle of a run aborts without a done pulse.
    start = 1'b1;
    c = 1;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 2;
    while (c < 100) begin
      if (done) seen = 1'b1;
      @(negedge clk);
      c++;
    end
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_neurons", {7'd0, neurons}, 32'd0);
    chk("abort_w_rd", {31'd0, w_rd}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
